// File: rtl/game_tick_scheduler_if.sv
// Control/status bundle between player inputs, the tick scheduler and the movement/score logic.
interface game_tick_scheduler_if;
  logic       start;
  logic       pause;
  logic       food_eaten;
  logic       game_over;
  logic       move_tick;
  logic [2:0] speed_level;
  logic [7:0] score;
  logic [1:0] state;

  modport master (
    output start, pause, food_eaten, game_over,
    input  move_tick, speed_level, score, state
  );

  modport slave (
    input  start, pause, food_eaten, game_over,
    output move_tick, speed_level, score, state
  );
endinterface

// File: rtl/game_tick_scheduler.sv
// Snake movement clock: programmable tick divider, idle/run/pause/over FSM, score and speed level.
// Optional feature: define GAME_TICK_SCHEDULER_BCD_SCORE_EN for a two-digit BCD score (saturates at 99).
module game_tick_scheduler #(
  parameter int unsigned BASE_PERIOD     = 50000000,
  parameter int unsigned MAX_LEVEL       = 4,
  parameter int unsigned FOODS_PER_LEVEL = 4
) (
  input logic                  clkin,
  input logic                  reset,
  game_tick_scheduler_if.slave bus
);
  localparam int unsigned CNT_W   = 26;
  localparam int unsigned LVL_W   = 3;
  localparam int unsigned SCORE_W = 8;
  localparam int unsigned SUB_W   = $clog2(FOODS_PER_LEVEL) + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_PAUSED = 2'b10,
    S_OVER   = 2'b11
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               move_tick_q, move_tick_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SUB_W-1:0]   sub_q, sub_d;
  logic [CNT_W-1:0]   period_m1;
  logic [SCORE_W-1:0] score_inc;
  logic               advance;
  logic               food_ok;

  assign period_m1 = CNT_W'(BASE_PERIOD >> level_q) - CNT_W'(1);

`ifdef GAME_TICK_SCHEDULER_BCD_SCORE_EN
  // Two-digit BCD increment, holding at 99.
  always_comb begin
    score_inc = score_q;
    if (score_q != 8'h99) begin
      if (score_q[3:0] == 4'd9) score_inc = {score_q[7:4] + 4'd1, 4'd0};
      else                      score_inc = {score_q[7:4], score_q[3:0] + 4'd1};
    end
  end
`else
  always_comb begin
    score_inc = score_q;
    if (score_q != 8'hFF) score_inc = score_q + 8'd1;
  end
`endif

  // Next-state: the counter advances only on edges that leave the FSM in RUN.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    move_tick_d = 1'b0;
    level_d     = level_q;
    score_d     = score_q;
    sub_d       = sub_q;
    advance     = 1'b0;
    food_ok     = 1'b0;

    case (state_q)
      S_IDLE, S_OVER: begin
        if (bus.start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          level_d = '0;
          score_d = '0;
          sub_d   = '0;
        end
      end
      S_RUN: begin
        if (bus.game_over) begin
          state_d = S_OVER;
        end else begin
          food_ok = bus.food_eaten;
          if (bus.pause) state_d = S_PAUSED;
          else           advance = 1'b1;
        end
      end
      S_PAUSED: begin
        if (bus.game_over) begin
          state_d = S_OVER;
        end else if (!bus.pause) begin
          state_d = S_RUN;
          advance = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // >= covers a counter left beyond a freshly shortened period.
    if (advance) begin
      if (cnt_q >= period_m1) begin
        move_tick_d = 1'b1;
        cnt_d       = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (food_ok) begin
      score_d = score_inc;
      if (sub_q == SUB_W'(FOODS_PER_LEVEL - 1)) begin
        sub_d = '0;
        if (level_q < LVL_W'(MAX_LEVEL)) level_d = level_q + LVL_W'(1);
      end else begin
        sub_d = sub_q + SUB_W'(1);
      end
    end
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      move_tick_q <= 1'b0;
      level_q     <= '0;
      score_q     <= '0;
      sub_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      move_tick_q <= move_tick_d;
      level_q     <= level_d;
      score_q     <= score_d;
      sub_q       <= sub_d;
    end
  end

  assign bus.move_tick   = move_tick_q;
  assign bus.speed_level = level_q;
  assign bus.score       = score_q;
  assign bus.state       = 2'(state_q);
endmodule

// File: tb/tb_game_tick_scheduler.sv
// Directed bench for game_tick_scheduler: BASE_PERIOD=16, MAX_LEVEL=3, FOODS_PER_LEVEL=2.
module tb_game_tick_scheduler;
  localparam int unsigned BASE = 16;
  localparam int unsigned MAXL = 3;
  localparam int unsigned FPL  = 2;

`ifdef GAME_TICK_SCHEDULER_BCD_SCORE_EN
  localparam logic [7:0] SCORE_10  = 8'h10;
  localparam logic [7:0] SCORE_120 = 8'h99;
  localparam logic [7:0] SCORE_300 = 8'h99;
`else
  localparam logic [7:0] SCORE_10  = 8'd10;
  localparam logic [7:0] SCORE_120 = 8'd120;
  localparam logic [7:0] SCORE_300 = 8'd255;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  game_tick_scheduler_if bus ();

  game_tick_scheduler #(
    .BASE_PERIOD     (BASE),
    .MAX_LEVEL       (MAXL),
    .FOODS_PER_LEVEL (FPL)
  ) dut (
    .clkin (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until move_tick is seen; n = steps taken, or -1 if none within 100 cycles.
  task automatic wait_tick(output int n);
    int i;
    n = -1;
    i = 0;
    while (n < 0 && i < 100) begin
      i++;
      step();
      if (bus.move_tick === 1'b1) n = i;
    end
  endtask

  task automatic pulse_food();
    bus.food_eaten = 1'b1;
    step();
    bus.food_eaten = 1'b0;
    step();
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.pause = 1'b0; bus.food_eaten = 1'b0; bus.game_over = 1'b0;
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.move_tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick: got %b want 0", bus.move_tick); end
    n_cmp++; if (bus.state !== 2'b00) begin n_bad++; $display("FAIL reset_state: got %b want 00", bus.state); end
    n_cmp++; if (bus.score !== 8'h00) begin n_bad++; $display("FAIL reset_score: got %h want 00", bus.score); end
    n_cmp++; if (bus.speed_level !== 3'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", bus.speed_level); end
    step(); step();
    rst = 1'b0;
    step(); step();
    n_cmp++; if (bus.state !== 2'b00) begin n_bad++; $display("FAIL idle_hold: got %b want 00", bus.state); end
  endtask

  task automatic test_period();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    n_cmp++; if (bus.state !== 2'b01) begin n_bad++; $display("FAIL start_state: got %b want 01", bus.state); end
    for (int k = 1; k <= 48; k++) begin
      logic exp_t;
      step();
      exp_t = (k % 16 == 0);
      n_cmp++;
      if (bus.move_tick !== exp_t) begin
        n_bad++; $display("FAIL period_tick cycle %0d: got %b want %b", k, bus.move_tick, exp_t);
      end
    end
  endtask

  task automatic test_food_level();
    int n;
    pulse_food(); pulse_food();
    n_cmp++; if (bus.score !== 8'd2) begin n_bad++; $display("FAIL food2_score: got %h want 02", bus.score); end
    n_cmp++; if (bus.speed_level !== 3'd1) begin n_bad++; $display("FAIL food2_level: got %0d want 1", bus.speed_level); end
    wait_tick(n);
    n_cmp++; if (n < 0) begin n_bad++; $display("FAIL lvl1_first_tick: got %0d want >0", n); end
    wait_tick(n);
    n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL lvl1_period: got %0d want 8", n); end
    for (int i = 0; i < 6; i++) pulse_food();
    n_cmp++; if (bus.score !== 8'd8) begin n_bad++; $display("FAIL food8_score: got %h want 08", bus.score); end
    n_cmp++; if (bus.speed_level !== 3'd3) begin n_bad++; $display("FAIL level_sat: got %0d want 3", bus.speed_level); end
    wait_tick(n);
    wait_tick(n);
    n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL lvl3_period: got %0d want 2", n); end
  endtask

  task automatic test_over_priority();
    int ticks;
    int n;
    bus.game_over = 1'b1; bus.pause = 1'b1;
    step();
    bus.game_over = 1'b0; bus.pause = 1'b0;
    n_cmp++; if (bus.state !== 2'b11) begin n_bad++; $display("FAIL over_state: got %b want 11", bus.state); end
    ticks = 0;
    for (int i = 0; i < 20; i++) begin step(); if (bus.move_tick === 1'b1) ticks++; end
    n_cmp++; if (ticks !== 0) begin n_bad++; $display("FAIL over_ticks: got %0d want 0", ticks); end
    pulse_food();
    n_cmp++; if (bus.score !== 8'd8) begin n_bad++; $display("FAIL over_score_hold: got %h want 08", bus.score); end
    n_cmp++; if (bus.speed_level !== 3'd3) begin n_bad++; $display("FAIL over_level_hold: got %0d want 3", bus.speed_level); end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    n_cmp++; if (bus.state !== 2'b01) begin n_bad++; $display("FAIL restart_state: got %b want 01", bus.state); end
    n_cmp++; if (bus.score !== 8'd0) begin n_bad++; $display("FAIL restart_score: got %h want 00", bus.score); end
    n_cmp++; if (bus.speed_level !== 3'd0) begin n_bad++; $display("FAIL restart_level: got %0d want 0", bus.speed_level); end
    wait_tick(n);
    n_cmp++; if (n !== 16) begin n_bad++; $display("FAIL restart_first_tick: got %0d want 16", n); end
  endtask

  task automatic test_pause();
    int ticks;
    int bad_state;
    int n;
    // Counter is 0 right after a tick; five more cycles brings it to 5.
    for (int i = 0; i < 5; i++) step();
    bus.pause = 1'b1;
    ticks = 0; bad_state = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.move_tick === 1'b1) ticks++;
      if (bus.state !== 2'b10) bad_state++;
    end
    bus.pause = 1'b0;
    n_cmp++; if (ticks !== 0) begin n_bad++; $display("FAIL pause_ticks: got %0d want 0", ticks); end
    n_cmp++; if (bad_state !== 0) begin n_bad++; $display("FAIL pause_state: got %0d bad cycles want 0", bad_state); end
    step();
    n_cmp++; if (bus.state !== 2'b01) begin n_bad++; $display("FAIL resume_state: got %b want 01", bus.state); end
    wait_tick(n);
    n_cmp++; if (n !== 10) begin n_bad++; $display("FAIL resume_tick: got %0d want 10", n); end
  endtask

  task automatic test_score_sat();
    bus.game_over = 1'b1; step(); bus.game_over = 1'b0;
    bus.start = 1'b1; step(); bus.start = 1'b0;
    for (int i = 0; i < 10; i++) pulse_food();
    n_cmp++; if (bus.score !== SCORE_10) begin n_bad++; $display("FAIL score_10: got %h want %h", bus.score, SCORE_10); end
    for (int i = 0; i < 110; i++) pulse_food();
    n_cmp++; if (bus.score !== SCORE_120) begin n_bad++; $display("FAIL score_120: got %h want %h", bus.score, SCORE_120); end
    for (int i = 0; i < 180; i++) pulse_food();
    n_cmp++; if (bus.score !== SCORE_300) begin n_bad++; $display("FAIL score_300: got %h want %h", bus.score, SCORE_300); end
    n_cmp++; if (bus.speed_level !== 3'd3) begin n_bad++; $display("FAIL score_level: got %0d want 3", bus.speed_level); end
  endtask

  task automatic test_reset_mid();
    int ticks;
    int bad_state;
    bus.game_over = 1'b1; step(); bus.game_over = 1'b0;
    bus.start = 1'b1; step(); bus.start = 1'b0;
    bus.food_eaten = 1'b1;
    step(); step(); step();
    bus.food_eaten = 1'b0;
    step(); step(); step(); step();
    n_cmp++; if (bus.score !== 8'd3) begin n_bad++; $display("FAIL mid_score: got %h want 03", bus.score); end
    n_cmp++; if (bus.speed_level !== 3'd1) begin n_bad++; $display("FAIL mid_level: got %0d want 1", bus.speed_level); end
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.state !== 2'b00) begin n_bad++; $display("FAIL async_state: got %b want 00", bus.state); end
    n_cmp++; if (bus.score !== 8'd0) begin n_bad++; $display("FAIL async_score: got %h want 00", bus.score); end
    n_cmp++; if (bus.speed_level !== 3'd0) begin n_bad++; $display("FAIL async_level: got %0d want 0", bus.speed_level); end
    n_cmp++; if (bus.move_tick !== 1'b0) begin n_bad++; $display("FAIL async_tick: got %b want 0", bus.move_tick); end
    step(); step();
    rst = 1'b0;
    ticks = 0; bad_state = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.move_tick === 1'b1) ticks++;
      if (bus.state !== 2'b00) bad_state++;
    end
    n_cmp++; if (ticks !== 0) begin n_bad++; $display("FAIL post_reset_ticks: got %0d want 0", ticks); end
    n_cmp++; if (bad_state !== 0) begin n_bad++; $display("FAIL post_reset_state: got %0d bad cycles want 0", bad_state); end
  endtask

  initial begin
    test_reset();
    test_period();
    test_food_level();
    test_over_priority();
    test_pause();
    test_score_sat();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/game_tick_scheduler.md
# game_tick_scheduler

Sequences the snake game's movement clock. It replaces the free-running fast/slow dividers with one programmable divider that emits single-cycle `move_tick` pulses. It runs an idle/run/pause/over state machine and tracks score. It raises speed level after every `FOODS_PER_LEVEL` food events. It sits between the player-control inputs and the snake movement/render logic, and its score output feeds the 7-segment hex decoders.

## Interface
- `BASE_PERIOD`, default 50000000: tick period in clkin cycles at level 0; must be ≥ 2^MAX_LEVEL·2.
- `MAX_LEVEL`, default 4: highest speed level (saturating).
- `FOODS_PER_LEVEL`, default 4: food events per level increment; ≥ 1.
- `clkin`  in  1  system clock; all state changes on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  level; sampled each cycle; begins/restarts a game from IDLE or OVER.
- `pause`  in  1  level; high holds the game frozen while in RUN/PAUSED.
- `food_eaten`  in  1  single-cycle pulse from collision logic.
- `game_over`  in  1  single-cycle pulse from collision logic.
- `move_tick`  out  1  one-cycle pulse: advance snake one cell.
- `speed_level`  out  3  current level, 0..MAX_LEVEL.
- `score`  out  8  food count (binary or BCD, see Configuration).
- `state`  out  2  00 IDLE, 01 RUN, 10 PAUSED, 11 OVER.

## Operation
- Reset (async, any time, including mid-game): state=IDLE, counter=0, `move_tick`=0, `speed_level`=0, `score`=0, food sub-counter=0.
- Period for level L = BASE_PERIOD >> L; the 26-bit counter counts 0..period-1.
- IDLE: counter held at 0; `start`=1 → RUN with counter=0, score=0, level=0.
- RUN: the counter increments each cycle. When counter == period-1, `move_tick`=1 for that cycle and the counter wraps to 0. If the counter is ≥ period-1 after a level increase, the tick fires in the next cycle and the counter wraps.
- RUN, `pause`=1 → PAUSED. In PAUSED the counter is frozen and no tick is produced. `pause`=0 → RUN and counting resumes from the frozen value.
- Transition priority within one cycle: `game_over` > `pause` > `start`. `start` in RUN or PAUSED is ignored.
- `game_over` in RUN/PAUSED → OVER. OVER holds score and level, emits no ticks, and the counter is held. `start` → RUN with fresh game state.
- `food_eaten` is counted only in RUN, including in the same cycle as `move_tick`. It is ignored in IDLE, PAUSED and OVER, and in the cycle `game_over` is taken.
- Each counted food event increments score (saturating) and the sub-counter. When the sub-counter reaches FOODS_PER_LEVEL it returns to 0 and the level increments, saturating at MAX_LEVEL. The sub-counter keeps cycling at max level.

## Timing
- All outputs are registered; `move_tick` is never high for two consecutive cycles.
- If `start` is sampled at edge N, the first `move_tick` is high during cycle N+period, i.e. exactly `period` cycles later. Ticks repeat every `period` cycles.
- Score and level update one cycle after the `food_eaten` edge. The new period applies to the comparison in the following cycle.
- State updates one cycle after the sampled control input. `move_tick` is 0 in any cycle where state ≠ RUN.

## Configuration
- `GAME_TICK_SCHEDULER_BCD_SCORE_EN` defined: `score[7:4]` holds the tens digit and `score[3:0]` the ones digit in BCD, saturating at 99. Increment 09→10 carries, and each nibble feeds a hex decoder directly.
- Undefined: `score` is plain binary, saturating at 255.

## Test plan
- BASE_PERIOD=16, start pulse at edge 0 → `move_tick` high in cycles 16, 32, 48; `state`=01.
- FOODS_PER_LEVEL=2, two `food_eaten` pulses in RUN → score=2, `speed_level`=1, subsequent ticks every 8 cycles; six more foods with MAX_LEVEL=3 → level stays 3 and period stays 2.
- `pause` high at counter=5 for 20 cycles → no ticks, `state`=10; after release the next tick comes 10 cycles later.
- `game_over` and `pause` in the same cycle → `state`=11 and ticks stop. `start` then gives score=0, level=0 and a first tick 16 cycles later.
- With BCD enabled, 10 foods → `score`=8'h10; 120 foods → 8'h99. Without BCD, 300 foods → 8'd255.
- `reset` asserted mid-RUN with counter=7 and score=3 → all outputs 0 asynchronously and `state`=00; no tick until the next `start`.
